// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Holds decoder control bits, operands, immediate, funct and register indices
// for the EX stage. Supports stall (hold), flush (bubble insertion) and a pair
// of saturating occupancy counters (real instructions vs. bubbles loaded).
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               cnt_clr_i,
  input  logic               valid_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [2:0]         ALUOp_i,
  input  logic               ALUSrc_i,
  input  logic               Branch_i,
  input  logic [DATA_W-1:0]  RS1data_i,
  input  logic [DATA_W-1:0]  RS2data_i,
  input  logic [DATA_W-1:0]  Imm_i,
  input  logic [9:0]         funct_i,
  input  logic [RADDR_W-1:0] RS1addr_i,
  input  logic [RADDR_W-1:0] RS2addr_i,
  input  logic [RADDR_W-1:0] RDaddr_i,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [2:0]         ALUOp_o,
  output logic               ALUSrc_o,
  output logic               Branch_o,
  output logic [DATA_W-1:0]  RS1data_o,
  output logic [DATA_W-1:0]  RS2data_o,
  output logic [DATA_W-1:0]  Imm_o,
  output logic [9:0]         funct_o,
  output logic [RADDR_W-1:0] RS1addr_o,
  output logic [RADDR_W-1:0] RS2addr_o,
  output logic [RADDR_W-1:0] RDaddr_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   instr_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               memread_q,  memread_d;
  logic               memwrite_q, memwrite_d;
  logic [2:0]         aluop_q,    aluop_d;
  logic               alusrc_q,   alusrc_d;
  logic               branch_q,   branch_d;
  logic [DATA_W-1:0]  rs1data_q,  rs1data_d;
  logic [DATA_W-1:0]  rs2data_q,  rs2data_d;
  logic [DATA_W-1:0]  imm_q,      imm_d;
  logic [9:0]         funct_q,    funct_d;
  logic [RADDR_W-1:0] rs1addr_q,  rs1addr_d;
  logic [RADDR_W-1:0] rs2addr_q,  rs2addr_d;
  logic [RADDR_W-1:0] rdaddr_q,   rdaddr_d;
  logic               valid_q,    valid_d;
  logic [CNT_W-1:0]   instr_cnt_q,  instr_cnt_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  // Event qualifiers shared by the stage mux and the counters
  logic load_en;
  logic rd_nonzero;
  logic instr_inc;
  logic bubble_inc;

  // Classify this edge: flush wins over stall, otherwise the entry is loaded.
  // A flush always loads a bubble; a load with valid_i low is also a bubble.
  always_comb begin
    load_en    = ~flush_i & ~stall_i;
    rd_nonzero = (RDaddr_i != '0);
    instr_inc  = load_en & valid_i;
    bubble_inc = flush_i | (load_en & ~valid_i);
  end

  // Next pipeline entry: zeros on flush, hold on stall, gated capture on load.
  // Control bits of a non-valid entry are forced off so a NOP can never write
  // memory or the register file; writes to x0 are also suppressed here.
  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    branch_d   = branch_q;
    rs1data_d  = rs1data_q;
    rs2data_d  = rs2data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    rs1addr_d  = rs1addr_q;
    rs2addr_d  = rs2addr_q;
    rdaddr_d   = rdaddr_q;
    valid_d    = valid_q;
    if (flush_i) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      aluop_d    = '0;
      alusrc_d   = 1'b0;
      branch_d   = 1'b0;
      rs1data_d  = '0;
      rs2data_d  = '0;
      imm_d      = '0;
      funct_d    = '0;
      rs1addr_d  = '0;
      rs2addr_d  = '0;
      rdaddr_d   = '0;
      valid_d    = 1'b0;
    end else if (load_en) begin
      regwrite_d = RegWrite_i & valid_i & rd_nonzero;
      memtoreg_d = MemtoReg_i & valid_i;
      memread_d  = MemRead_i & valid_i;
      memwrite_d = MemWrite_i & valid_i;
      aluop_d    = valid_i ? ALUOp_i : 3'b000;
      alusrc_d   = ALUSrc_i & valid_i;
      branch_d   = Branch_i & valid_i;
      rs1data_d  = RS1data_i;
      rs2data_d  = RS2data_i;
      imm_d      = Imm_i;
      funct_d    = funct_i;
      rs1addr_d  = RS1addr_i;
      rs2addr_d  = RS2addr_i;
      rdaddr_d   = RDaddr_i;
      valid_d    = valid_i;
    end
  end

  // Saturating occupancy counters; a clear request wins over any increment
  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr_i) begin
      instr_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (instr_inc && (instr_cnt_q != CNT_MAX)) begin
        instr_cnt_d = instr_cnt_q + CNT_ONE;
      end
      if (bubble_inc && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end
  end

  // State register; reset leaves a bubble in EX with both counters cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      aluop_q      <= '0;
      alusrc_q     <= 1'b0;
      branch_q     <= 1'b0;
      rs1data_q    <= '0;
      rs2data_q    <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      rs1addr_q    <= '0;
      rs2addr_q    <= '0;
      rdaddr_q     <= '0;
      valid_q      <= 1'b0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      aluop_q      <= aluop_d;
      alusrc_q     <= alusrc_d;
      branch_q     <= branch_d;
      rs1data_q    <= rs1data_d;
      rs2data_q    <= rs2data_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      rs1addr_q    <= rs1addr_d;
      rs2addr_q    <= rs2addr_d;
      rdaddr_q     <= rdaddr_d;
      valid_q      <= valid_d;
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign RegWrite_o   = regwrite_q;
  assign MemtoReg_o   = memtoreg_q;
  assign MemRead_o    = memread_q;
  assign MemWrite_o   = memwrite_q;
  assign ALUOp_o      = aluop_q;
  assign ALUSrc_o     = alusrc_q;
  assign Branch_o     = branch_q;
  assign RS1data_o    = rs1data_q;
  assign RS2data_o    = rs2data_q;
  assign Imm_o        = imm_q;
  assign funct_o      = funct_q;
  assign RS1addr_o    = rs1addr_q;
  assign RS2addr_o    = rs2addr_q;
  assign RDaddr_o     = rdaddr_q;
  assign valid_o      = valid_q;
  assign instr_cnt_o  = instr_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
